// File: rtl/rs_pkg.sv
// Shared GF(2^8) definitions for the RS(68,64) encoder/decoder pair: field constants,
// arithmetic helpers, the symbol type and the decoder FSM state encoding.
package rs_pkg;

  typedef logic [7:0] sym_t;

  localparam int unsigned RS_N    = 68;
  localparam int unsigned RS_K    = 64;
  localparam int unsigned RS_NPAR = 4;
  localparam sym_t        GF_POLY = 8'h1D;

  localparam sym_t ALPHA_POW [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  typedef enum logic [2:0] {
    StIdle,
    StSynd,
    StSolve,
    StChien,
    StDone
  } rs_state_e;

  function automatic sym_t gf_mul(sym_t a, sym_t b);
    sym_t acc;
    sym_t sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF_POLY : 8'h00);
    end
    return acc;
  endfunction

  // inv(alpha^i) = alpha^(255-i); entry 0 stays 0.
  function automatic logic [255:0][7:0] gen_inv_tbl();
    logic [255:0][7:0] tbl;
    logic [254:0][7:0] pw;
    tbl   = '0;
    pw    = '0;
    pw[0] = 8'h01;
    for (int i = 1; i < 255; i++) pw[i] = gf_mul(pw[i-1], 8'h02);
    for (int i = 0; i < 255; i++) tbl[pw[i]] = pw[(255 - i) % 255];
    return tbl;
  endfunction

  localparam logic [255:0][7:0] GF_INV_TBL = gen_inv_tbl();

  function automatic sym_t gf_inv(sym_t a);
    return GF_INV_TBL[a];
  endfunction

endpackage

// File: rtl/rs_decoder_syndrome.sv
// Four parallel Horner accumulators S_k <= S_k*alpha^k ^ sym, one received symbol per cycle.
module rs_syndrome
  import rs_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic start_i,
  input  logic shift_i,
  input  sym_t sym_i,
  output sym_t synd_o [RS_NPAR]
);

  sym_t synd_q [RS_NPAR];

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < RS_NPAR; k++) begin
      if (rst_i || clear_i) begin
        synd_q[k] <= '0;
      end else if (start_i) begin
        synd_q[k] <= sym_i;
      end else if (shift_i) begin
        synd_q[k] <= gf_mul(synd_q[k], ALPHA_POW[k]) ^ sym_i;
      end
    end
  end

  assign synd_o = synd_q;

endmodule

// File: rtl/rs_decoder.sv
// Iterative RS(68,64) decoder, t=2: syndromes, PGZ solve, Chien/Forney correction.
// Optional RS_DEC_STATS_EN adds saturating corrected-symbol and failed-frame counters.
module rs_decoder
  import rs_pkg::*;
#(
  parameter int unsigned CHIEN_PAR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  sym_t        cw_in [RS_N],
  input  logic        cw_valid,
  output logic        cw_ready,
  output sym_t        msg_out [RS_K],
  output logic        msg_valid,
  input  logic        msg_ready,
  output logic [1:0]  err_cnt,
  output logic        err_fail
`ifdef RS_DEC_STATS_EN
  ,
  output logic [31:0] stat_corr_syms,
  output logic [31:0] stat_fail_frames
`endif
);

  localparam int unsigned CHIEN_CYC  = RS_N / CHIEN_PAR;
  localparam logic [6:0]  SYND_LAST  = 7'(RS_N - 1);
  localparam logic [6:0]  CHIEN_LAST = 7'(CHIEN_CYC - 1);

  rs_state_e   state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  sym_t        buf_q [RS_N];
  sym_t        raw_q [RS_N];
  sym_t        buf_corr [RS_N];
  sym_t        synd [RS_NPAR];
  sym_t        det_q, n1_q, n2_q, inv_q;
  sym_t        lam1_q, lam2_q, c0_q, c1_q, cs_q, x_q;
  logic [1:0]  deg_q;
  logic        fail_q;
  logic [2:0]  roots_q, hits, roots_total;
  logic [1:0]  err_cnt_q;
  logic        err_fail_q;
  logic        accept, search_en, fin_fail;
  sym_t        xj, qv;
  logic [6:0]  pos;

  assign accept = (state_q == StIdle) && cw_valid;

  rs_syndrome u_synd (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (accept),
    .start_i ((state_q == StSynd) && (cnt_q == 7'd0)),
    .shift_i (state_q == StSynd),
    .sym_i   (buf_q[cnt_q]),
    .synd_o  (synd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (cw_valid) begin
          state_d = StSynd;
          cnt_d   = '0;
        end
      end
      StSynd: begin
        if (cnt_q == SYND_LAST) begin
          state_d = StSolve;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      StSolve: begin
        if (cnt_q == 7'd3) begin
          state_d = StChien;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      StChien: begin
        if (cnt_q == CHIEN_LAST) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      StDone: begin
        if (msg_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Roots tested on the reversed locator X^2 + lam1*X + lam2 at X = alpha^(67-pos);
  // a single-error locator has lam2 = 0, so its only nonzero root is lam1.
  assign search_en = (state_q == StChien) && (deg_q != 2'd0) && !fail_q;

  always_comb begin
    buf_corr = buf_q;
    hits     = '0;
    xj       = '0;
    qv       = '0;
    pos      = '0;
    for (int j = 0; j < CHIEN_PAR; j++) begin
      xj  = gf_mul(x_q, ALPHA_POW[j]);
      qv  = gf_mul(xj, xj ^ lam1_q) ^ lam2_q;
      pos = 7'(int'(RS_N) - 1 - int'(cnt_q) * int'(CHIEN_PAR) - j);
      if (search_en && (qv == 8'h00)) begin
        buf_corr[pos] = buf_corr[pos] ^ gf_mul(c0_q ^ gf_mul(c1_q, xj), cs_q);
        hits          = hits + 3'd1;
      end
    end
  end

  assign roots_total = roots_q + hits;
  assign fin_fail    = fail_q || (roots_total != {1'b0, deg_q});

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q      <= '{default: '0};
      raw_q      <= '{default: '0};
      det_q      <= '0;
      n1_q       <= '0;
      n2_q       <= '0;
      inv_q      <= '0;
      lam1_q     <= '0;
      lam2_q     <= '0;
      c0_q       <= '0;
      c1_q       <= '0;
      cs_q       <= '0;
      x_q        <= 8'h01;
      deg_q      <= '0;
      fail_q     <= 1'b0;
      roots_q    <= '0;
      err_cnt_q  <= '0;
      err_fail_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cw_valid) begin
            buf_q      <= cw_in;
            raw_q      <= cw_in;
            lam1_q     <= '0;
            lam2_q     <= '0;
            x_q        <= 8'h01;
            deg_q      <= '0;
            fail_q     <= 1'b0;
            roots_q    <= '0;
            err_cnt_q  <= '0;
            err_fail_q <= 1'b0;
          end
        end
        StSolve: begin
          case (cnt_q[1:0])
            2'd0: begin
              det_q <= gf_mul(synd[1], synd[1]) ^ gf_mul(synd[0], synd[2]);
              n1_q  <= gf_mul(synd[2], synd[1]) ^ gf_mul(synd[0], synd[3]);
              n2_q  <= gf_mul(synd[1], synd[3]) ^ gf_mul(synd[2], synd[2]);
            end
            2'd1: inv_q <= gf_inv((det_q != 8'h00) ? det_q : synd[0]);
            2'd2: begin
              if ((synd[0] | synd[1] | synd[2] | synd[3]) == 8'h00) begin
                deg_q <= 2'd0;
              end else if (det_q != 8'h00) begin
                lam1_q <= gf_mul(n1_q, inv_q);
                lam2_q <= gf_mul(n2_q, inv_q);
                deg_q  <= 2'd2;
              end else if (synd[0] != 8'h00) begin
                lam1_q <= gf_mul(synd[1], inv_q);
                lam2_q <= '0;
                deg_q  <= 2'd1;
              end else begin
                fail_q <= 1'b1;
              end
            end
            default: begin
              // Forney as Y = (c0 ^ c1*X) * cs; two errors use the partner root lam1 ^ X.
              if (deg_q == 2'd2) begin
                c0_q <= synd[1] ^ gf_mul(synd[0], lam1_q);
                c1_q <= synd[0];
                cs_q <= gf_inv(lam1_q);
              end else if (deg_q == 2'd1) begin
                c0_q <= synd[0];
                c1_q <= '0;
                cs_q <= 8'h01;
                if ((synd[2] != gf_mul(synd[1], lam1_q)) ||
                    (synd[3] != gf_mul(synd[2], lam1_q))) begin
                  fail_q <= 1'b1;
                end
              end
            end
          endcase
        end
        StChien: begin
          x_q     <= gf_mul(x_q, ALPHA_POW[CHIEN_PAR]);
          roots_q <= roots_total;
          if (cnt_q == CHIEN_LAST && fin_fail) begin
            buf_q      <= raw_q;
            err_fail_q <= 1'b1;
            err_cnt_q  <= '0;
          end else begin
            buf_q <= buf_corr;
            if (cnt_q == CHIEN_LAST) err_cnt_q <= deg_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign cw_ready  = (state_q == StIdle);
  assign msg_valid = (state_q == StDone);
  assign err_cnt   = err_cnt_q;
  assign err_fail  = err_fail_q;

  always_comb begin
    for (int i = 0; i < RS_K; i++) msg_out[i] = buf_q[i];
  end

`ifdef RS_DEC_STATS_EN
  logic [31:0] stat_corr_q, stat_fail_q;
  logic [32:0] corr_sum;

  assign corr_sum = {1'b0, stat_corr_q} + {31'b0, err_cnt_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_corr_q <= '0;
      stat_fail_q <= '0;
    end else if (msg_valid && msg_ready) begin
      stat_corr_q <= corr_sum[32] ? '1 : corr_sum[31:0];
      if (err_fail_q && (stat_fail_q != '1)) stat_fail_q <= stat_fail_q + 32'd1;
    end
  end

  assign stat_corr_syms   = stat_corr_q;
  assign stat_fail_frames = stat_fail_q;
`endif

endmodule

// File: tb/tb_rs_decoder.sv
// Directed self-checking bench for rs_decoder: clean, 1/2/3-error frames, backpressure, mid-frame reset.
module tb_rs_decoder;

  localparam int P       = 1;
  localparam int N       = 68;
  localparam int K       = 64;
  localparam int EXP_LAT = 73 + N / P;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cw_in [N];
  logic       cw_valid;
  logic       cw_ready;
  logic [7:0] msg_out [K];
  logic       msg_valid;
  logic       msg_ready;
  logic [1:0] err_cnt;
  logic       err_fail;
`ifdef RS_DEC_STATS_EN
  logic [31:0] stat_corr_syms, stat_fail_frames;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] msg_ref [K];
  logic [7:0] exp_msg [K];
  logic [7:0] frame [N];
  logic [7:0] gen [5];

  always #5 clk = ~clk;

  rs_decoder #(.CHIEN_PAR(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .cw_in     (cw_in),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready),
    .msg_out   (msg_out),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .err_cnt   (err_cnt),
    .err_fail  (err_fail)
`ifdef RS_DEC_STATS_EN
    ,
    .stat_corr_syms   (stat_corr_syms),
    .stat_fail_frames (stat_fail_frames)
`endif
  );

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1D : 8'h00);
      if (a[i]) r = r ^ b;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // g(x) = (x+1)(x+a)(x+a^2)(x+a^3)
  task automatic make_gen();
    logic [7:0] a;
    gen = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    a   = 8'h01;
    for (int k = 0; k < 4; k++) begin
      for (int d = 4; d >= 1; d--) gen[d] = gen[d-1] ^ mul(a, gen[d]);
      gen[0] = mul(a, gen[0]);
      a      = mul(a, 8'h02);
    end
  endtask

  task automatic build_frame();
    logic [7:0] r3, r2, r1, r0, fb;
    r3 = 0; r2 = 0; r1 = 0; r0 = 0;
    for (int i = 0; i < K; i++) begin
      frame[i] = msg_ref[i];
      fb = msg_ref[i] ^ r3;
      r3 = r2 ^ mul(fb, gen[3]);
      r2 = r1 ^ mul(fb, gen[2]);
      r1 = r0 ^ mul(fb, gen[1]);
      r0 = mul(fb, gen[0]);
    end
    frame[64] = r3; frame[65] = r2; frame[66] = r1; frame[67] = r0;
  endtask

  task automatic send();
    cw_in    = frame;
    cw_valid = 1'b1;
    chk("cw_ready_at_accept", cw_ready, 1);
    tick();
    cw_valid = 1'b0;
  endtask

  task automatic wait_result();
    int lat;
    lat = 1;
    while (msg_valid !== 1'b1 && lat < 400) begin
      tick();
      lat++;
    end
    chk("latency", lat, EXP_LAT);
  endtask

  task automatic check_result(input int unsigned ecnt, input int unsigned efail);
    for (int i = 0; i < K; i++) chk($sformatf("msg_out[%0d]", i), msg_out[i], exp_msg[i]);
    chk("err_cnt", err_cnt, ecnt);
    chk("err_fail", err_fail, efail);
    chk("cw_ready_in_done", cw_ready, 0);
  endtask

  task automatic handshake();
    msg_ready = 1'b1;
    tick();
    msg_ready = 1'b0;
    chk("msg_valid_after_hs", msg_valid, 0);
  endtask

  task automatic clean_msg();
    for (int i = 0; i < K; i++) msg_ref[i] = 8'(i + 1);
    build_frame();
    exp_msg = msg_ref;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst       = 1'b1;
    cw_valid  = 1'b0;
    msg_ready = 1'b0;
    cw_in     = '{default: 8'h00};
    make_gen();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_cw_ready", cw_ready, 1);
    chk("rst_msg_valid", msg_valid, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_err_fail", err_fail, 0);
    for (int i = 0; i < K; i++) chk($sformatf("rst_msg_out[%0d]", i), msg_out[i], 0);

    // Clean frame
    clean_msg();
    send();
    wait_result();
    check_result(0, 0);
    handshake();

    // Single message error
    clean_msg();
    frame[5] = frame[5] ^ 8'h5A;
    send();
    wait_result();
    check_result(1, 0);
    handshake();

    // One message error plus one parity error
    clean_msg();
    frame[0]  = frame[0] ^ 8'h01;
    frame[66] = frame[66] ^ 8'hFF;
    send();
    wait_result();
    check_result(2, 0);
    handshake();

    // Three errors on the zero codeword with S0 = S1 = 0: no weight<=2 pattern fits
    frame = '{default: 8'h00};
    frame[5] = 8'h03;
    frame[6] = 8'h05;
    frame[7] = 8'h06;
    for (int i = 0; i < K; i++) exp_msg[i] = frame[i];
    send();
    wait_result();
    check_result(0, 1);
    handshake();

    // Backpressure with a second frame offered while DONE is held
    clean_msg();
    frame[20] = frame[20] ^ 8'h33;
    send();
    wait_result();
    check_result(1, 0);
    for (int i = 0; i < K; i++) msg_ref[i] = 8'hA0 ^ 8'(i);
    build_frame();
    frame[63] = frame[63] ^ 8'hC3;
    cw_in    = frame;
    cw_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk("bp_msg_valid", msg_valid, 1);
      chk("bp_cw_ready", cw_ready, 0);
      chk("bp_err_cnt", err_cnt, 1);
      chk("bp_msg_out[20]", msg_out[20], exp_msg[20]);
      chk("bp_msg_out[63]", msg_out[63], exp_msg[63]);
      tick();
    end
    msg_ready = 1'b1;
    tick();
    msg_ready = 1'b0;
    chk("bp_msg_valid_after_hs", msg_valid, 0);
    chk("bp_cw_ready_after_hs", cw_ready, 1);
    tick();
    cw_valid = 1'b0;
    wait_result();
    exp_msg = msg_ref;
    check_result(1, 0);
    handshake();

    // Reset pulse during CHIEN
    clean_msg();
    send();
    repeat (99) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_cw_ready", cw_ready, 1);
    chk("midrst_msg_valid", msg_valid, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    chk("midrst_msg_out[0]", msg_out[0], 0);
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      if (msg_valid === 1'b1) seen++;
      tick();
    end
    chk("midrst_no_result", seen, 0);
    clean_msg();
    frame[40] = frame[40] ^ 8'h81;
    frame[3]  = frame[3] ^ 8'h10;
    send();
    wait_result();
    check_result(2, 0);
    handshake();
    clean_msg();
    send();
    wait_result();
    check_result(0, 0);
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rs_decoder.md
Name: rs_decoder

Overview:
- Iterative RS(68,64) decoder over GF(2^8); corrects up to t=2 symbol errors per frame.
- Receive-side partner of the existing 64-symbol / 4-parity encoder. Same field, same frame shape.
- Accepts one full parallel codeword and returns the 64 corrected message symbols plus error status.
- Valid/ready handshakes on both sides. One frame in flight.

Parameters:
CHIEN_PAR, 1, codeword positions searched per cycle in CHIEN; legal values 1, 2, 4 (must divide 68).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cw_in  in  8 x [68]  received codeword: [0..63] message symbols, [64..67] parity symbols 0..3
cw_valid  in  1  codeword present
cw_ready  out  1  decoder can accept
msg_out  out  8 x [64]  corrected message
msg_valid  out  1  result present
msg_ready  in  1  downstream accepts result
err_cnt  out  2  symbols corrected (0, 1 or 2)
err_fail  out  1  uncorrectable frame

Behaviour:
- Reset: one clock, synchronous, active-high; polarity and synchronicity are fixed.
- Code convention:
  - Field polynomial x^8+x^4+x^3+x^2+1 (0x11D); alpha = 0x02.
  - Polynomial r(x) = sum cw_in[i]*x^(67-i).
  - Syndromes S_k = r(alpha^k), k = 0..3.
- Reset state: FSM in IDLE; cw_ready=1; msg_valid=0; err_cnt=0; err_fail=0; msg_out=0.
- FSM states: IDLE -> SYND -> SOLVE -> CHIEN -> DONE -> IDLE.
- IDLE:
  - cw_ready=1.
  - On cw_valid, latch cw_in into the frame buffer, clear syndromes, go to SYND.
  - The acceptance cycle is cycle 0.
- SYND:
  - 68 cycles, one symbol per cycle, Horner update S_k <= S_k*alpha^k ^ buf[n], for n = 0..67.
- SOLVE: 4 cycles, fixed.
  - All S_k = 0: err_cnt=0, skip the search; CHIEN still runs so latency stays fixed.
  - det = S1^2 ^ S0*S2 nonzero: two-error locator from the Peterson-Gorenstein-Zierler (PGZ) formulas, using gf_inv(det).
  - det = 0 and S0 != 0: single-error locator lambda1 = S1/S0.
  - Single-error consistency check: S2 must equal S1*lambda1 and S3 must equal S2*lambda1. Otherwise mark fail.
  - Any other case: mark fail.
- CHIEN:
  - 68/CHIEN_PAR cycles.
  - Evaluate the locator at each position; on a root, compute the magnitude (Forney) and XOR it into the buffer.
  - Parity positions are corrected too but are not output.
  - If the root count differs from the locator degree: mark fail, discard corrections, restore the raw buffer (a shadow copy is kept).
- DONE:
  - msg_valid=1; msg_out, err_cnt and err_fail stable, held until msg_ready.
  - On msg_valid & msg_ready: go to IDLE, msg_valid=0 next cycle.
- Latency (CHIEN_PAR=1): msg_valid first high at cycle 141 (SYND 1-68, SOLVE 69-72, CHIEN 73-140).
  - General case: 73 + 68/CHIEN_PAR.
- Throughput: cw_ready is low outside IDLE. A cw_valid arriving in the same cycle as a DONE handshake is accepted the cycle after.
- On fail: msg_out = uncorrected received message symbols, err_cnt=0, err_fail=1.
- Reset mid-frame: frame dropped, all outputs return to reset values on the next edge; no partial result is emitted.
- GF arithmetic: XOR add; shift-and-reduce multiply; inverse by a constant 256-entry table; gf_inv(0) returns 0 and is never used on a valid path.

Optional Feature:
- Macro RS_DEC_STATS_EN.
- When defined:
  - Adds ports stat_corr_syms (out, 32) and stat_fail_frames (out, 32).
  - Both are saturating counters, incremented at each DONE handshake by err_cnt or by err_fail respectively.
  - Cleared only by rst.
- When undefined: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package rs_pkg holds:
  - constants RS_N=68, RS_K=64, RS_NPAR=4, GF_POLY=8'h1D, ALPHA_POW table;
  - functions gf_mul and gf_inv;
  - typedef sym_t (logic [7:0]);
  - the FSM state enum.
- The encoder migrates to the same package.
- One sub-module, rs_syndrome: 4 parallel Horner accumulators with constant multipliers, start/shift/clear controls.

Test Plan:
- Clean frame, message i -> i+1 passed through the encoder model to get parity: msg_out equals the input, err_cnt=0, err_fail=0, msg_valid at cycle 141.
- Same frame with cw_in[5]^=0x5A: msg_out[5] restored, err_cnt=1, err_fail=0.
- Same frame with cw_in[0]^=0x01 and cw_in[66]^=0xFF (one message error, one parity error): message restored, err_cnt=2.
- Three-error pattern on an all-zero codeword, confirmed undecodable by the reference model: err_fail=1, err_cnt=0, msg_out = raw received symbols.
- Backpressure: msg_ready held low 10 cycles after msg_valid:
  - outputs stable throughout, cw_ready=0, a second cw_valid is ignored;
  - after the handshake, the second frame is accepted one cycle later.
- rst pulsed during CHIEN: next cycle cw_ready=1, msg_valid=0, no result emitted; a following clean frame decodes correctly.
